// File: rtl/ups_pkg.sv
// Shared types and constants for the UPS run-mode sequencer.
// Phase encoding doubles as the status-word phase field.
package ups_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_PRE  = 3'd1,
    PH_RUN  = 3'd2,
    PH_POST = 3'd3,
    PH_DONE = 3'd4
  } phase_e;

  localparam logic [1:0] MODE_DEBUG = 2'd2;
  localparam logic [1:0] MODE_RUN   = 2'd3;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_ABORT    = 2;
  localparam int ST_PH_LSB   = 3;
  localparam int ST_LOOP_LSB = 16;

endpackage

// File: rtl/ups_run_sequencer_if.sv
// Register-file side bundle of the run sequencer.
// master = register file, slave = sequencer.
interface ups_run_sequencer_if;
  logic [1:0]  mode;
  logic [15:0] loops;
  logic [31:0] pre_cnt;
  logic [31:0] run_cnt;
  logic [31:0] post_cnt;
  logic        start_stb;
  logic        stop_stb;
  logic        valve_req;
  logic        valve;
  logic        dac_sel;
  logic [2:0]  phase;
  logic        busy;
  logic        done;
  logic [15:0] loop_cnt;
  logic [31:0] status;

  modport master (
    output mode, loops, pre_cnt, run_cnt, post_cnt,
    output start_stb, stop_stb, valve_req,
    input  valve, dac_sel, phase, busy, done,
    input  loop_cnt, status
  );

  modport slave (
    input  mode, loops, pre_cnt, run_cnt, post_cnt,
    input  start_stb, stop_stb, valve_req,
    output valve, dac_sel, phase, busy, done,
    output loop_cnt, status
  );
endinterface

// File: rtl/ups_tick_gen.sv
// Dwell-tick prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Tick is independent of clr so phase changes can use it combinationally.
module ups_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == LAST);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ups_run_sequencer.sv
// UPS run-mode sequencer: PRE/RUN/POST loops with dwell timing,
// valve and DAC-select drive, and the status readback word.
module ups_run_sequencer
  import ups_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input logic clk,
  input logic rst,
  ups_run_sequencer_if.slave bus
);

  phase_e      state_q, state_d;
  logic [31:0] dwell_q, dwell_d;
  logic [15:0] loop_q, loop_d;
  logic [15:0] sh_loops_q, sh_loops_d;
  logic [31:0] sh_pre_q, sh_pre_d;
  logic [31:0] sh_run_q, sh_run_d;
  logic [31:0] sh_post_q, sh_post_d;
  logic        aborted_q, aborted_d;
  logic        valve_q, valve_d;
  logic        dac_q, dac_d;

  logic tick;
  logic clr;
  logic busy;
  logic run_mode;
  logic start_ok;
  logic dwell_end;

  assign busy = (state_q == PH_PRE) || (state_q == PH_RUN)
             || (state_q == PH_POST);

  ups_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (busy),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    loop_d     = loop_q;
    sh_loops_d = sh_loops_q;
    sh_pre_d   = sh_pre_q;
    sh_run_d   = sh_run_q;
    sh_post_d  = sh_post_q;
    aborted_d  = aborted_q;
    run_mode   = (bus.mode == MODE_RUN);
    start_ok   = bus.start_stb && run_mode && !bus.stop_stb;
    // A zero count ends its phase after one cycle, no tick needed.
    dwell_end  = (dwell_q == '0) || (tick && dwell_q == 32'd1);

    if (tick && dwell_q != '0) dwell_d = dwell_q - 32'd1;

    if (busy && (bus.stop_stb || !run_mode)) begin
      state_d   = PH_IDLE;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        PH_IDLE, PH_DONE: begin
          if (start_ok) begin
            sh_loops_d = bus.loops;
            sh_pre_d   = bus.pre_cnt;
            sh_run_d   = bus.run_cnt;
            sh_post_d  = bus.post_cnt;
            loop_d     = '0;
            aborted_d  = 1'b0;
            if (bus.loops == '0) begin
              state_d = PH_DONE;
            end else begin
              state_d = PH_PRE;
              dwell_d = bus.pre_cnt;
            end
          end else if (state_q == PH_DONE
                       && (bus.stop_stb || !run_mode)) begin
            state_d = PH_IDLE;
          end
        end
        PH_PRE: begin
          if (dwell_end) begin
            state_d = PH_RUN;
            dwell_d = sh_run_q;
          end
        end
        PH_RUN: begin
          if (dwell_end) begin
            state_d = PH_POST;
            dwell_d = sh_post_q;
          end
        end
        PH_POST: begin
          if (dwell_end) begin
            loop_d = loop_q + 16'd1;
            if ({1'b0, loop_q} + 17'd1 < {1'b0, sh_loops_q}) begin
              state_d = PH_PRE;
              dwell_d = sh_pre_q;
            end else begin
              state_d = PH_DONE;
            end
          end
        end
        default: state_d = PH_IDLE;
      endcase
    end

    clr = (state_d != state_q);

    valve_d = 1'b0;
    unique case (1'b1)
      bus.mode == MODE_DEBUG: valve_d = bus.valve_req;
      run_mode:               valve_d = (state_d == PH_RUN);
      default:                valve_d = 1'b0;
    endcase
    dac_d = (state_d == PH_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PH_IDLE;
      dwell_q    <= '0;
      loop_q     <= '0;
      sh_loops_q <= '0;
      sh_pre_q   <= '0;
      sh_run_q   <= '0;
      sh_post_q  <= '0;
      aborted_q  <= 1'b0;
      valve_q    <= 1'b0;
      dac_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      loop_q     <= loop_d;
      sh_loops_q <= sh_loops_d;
      sh_pre_q   <= sh_pre_d;
      sh_run_q   <= sh_run_d;
      sh_post_q  <= sh_post_d;
      aborted_q  <= aborted_d;
      valve_q    <= valve_d;
      dac_q      <= dac_d;
    end
  end

  always_comb begin
    bus.status = '0;
    bus.status[ST_BUSY]            = busy;
    bus.status[ST_DONE]            = (state_q == PH_DONE);
    bus.status[ST_ABORT]           = aborted_q;
    bus.status[ST_PH_LSB +: 3]     = state_q;
    bus.status[ST_LOOP_LSB +: 16]  = loop_q;
  end

  assign bus.valve    = valve_q;
  assign bus.dac_sel  = dac_q;
  assign bus.phase    = state_q;
  assign bus.busy     = busy;
  assign bus.done     = (state_q == PH_DONE);
  assign bus.loop_cnt = loop_q;

endmodule
